// File: rtl/sonic_echo_responder.sv
// HC-SR04-style responder: Trig in (2-flop synchronised), Echo out whose width encodes distance_cm.
// Echo rises ECHO_DELAY_CYC cycles after an accepted Trig fall; optional range jitter under `ifdef ECHO_JITTER_EN.
// No backpressure: Trig is ignored while a measurement is busy; a too-short Trig pulses trig_err.
module sonic_echo_responder #(
    parameter int TRIG_MIN_CYC   = 1000,
    parameter int ECHO_DELAY_CYC = 50000,
    parameter int CYC_PER_CM     = 5800,
    parameter int MAX_CM         = 400,
    parameter int TIMEOUT_CYC    = 3800000,
    parameter int HOLDOFF_CYC    = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared down-counter serves delay, cm sub-period (plus jitter), timeout and holdoff.
    localparam int CNT_MAX = max2(max2(TIMEOUT_CYC, HOLDOFF_CYC), max2(ECHO_DELAY_CYC, 2 * CYC_PER_CM));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WID_W   = $clog2(TRIG_MIN_CYC + 1);
    localparam int CM_W    = $clog2(MAX_CM + 1);

    typedef enum logic [2:0] {IDLE, TRIG_HI, DELAY, ECHO, HOLDOFF} state_t;

    state_t            state;
    logic              trig_m, trig_s, trig_s_d;
    logic [WID_W-1:0]  wcnt;
    logic [CNT_W-1:0]  cnt;
    logic [CM_W-1:0]   cm_cnt;
    logic [8:0]        latched_cm;
    logic              tmo;
    logic              cm_valid;
    logic [CNT_W-1:0]  jit_add;

    assign cm_valid = (latched_cm != 9'd0) && (latched_cm <= 9'(MAX_CM));

`ifdef ECHO_JITTER_EN
    logic [7:0] lfsr;
    assign jit_add = CNT_W'((32'(lfsr[3:0]) * 32'(CYC_PER_CM)) >> 4);
`else
    assign jit_add = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            trig_m     <= 1'b0;
            trig_s     <= 1'b0;
            trig_s_d   <= 1'b0;
            wcnt       <= '0;
            cnt        <= '0;
            cm_cnt     <= '0;
            latched_cm <= '0;
            tmo        <= 1'b0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            trig_err   <= 1'b0;
`ifdef ECHO_JITTER_EN
            lfsr       <= 8'hA5;
`endif
        end else begin
            trig_m   <= trig;
            trig_s   <= trig_m;
            trig_s_d <= trig_s;
            trig_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Edge, not level: a Trig still high when holdoff ends is not a new request.
                    if (trig_s && !trig_s_d) begin
                        state <= TRIG_HI;
                        busy  <= 1'b1;
                        wcnt  <= WID_W'(1);
                    end
                end
                TRIG_HI: begin
                    if (trig_s) begin
                        if (wcnt != WID_W'(TRIG_MIN_CYC)) wcnt <= wcnt + WID_W'(1);
                    end else if (wcnt == WID_W'(TRIG_MIN_CYC)) begin
                        state      <= DELAY;
                        latched_cm <= distance_cm;
                        cnt        <= CNT_W'(ECHO_DELAY_CYC - 1);
`ifdef ECHO_JITTER_EN
                        lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
                    end else begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        trig_err <= 1'b1;
                    end
                end
                DELAY: begin
                    if (cnt == '0) begin
                        state <= ECHO;
                        echo  <= 1'b1;
                        if (cm_valid) begin
                            tmo    <= 1'b0;
                            cm_cnt <= CM_W'(latched_cm);
                            cnt    <= CNT_W'(CYC_PER_CM - 1) + jit_add;
                        end else begin
                            tmo <= 1'b1;
                            cnt <= CNT_W'(TIMEOUT_CYC - 1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ECHO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (tmo || cm_cnt == CM_W'(1)) begin
                        state <= HOLDOFF;
                        echo  <= 1'b0;
                        cnt   <= CNT_W'(HOLDOFF_CYC - 1);
                    end else begin
                        cm_cnt <= cm_cnt - CM_W'(1);
                        cnt    <= CNT_W'(CYC_PER_CM - 1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Directed bench for sonic_echo_responder: table of Trig/distance vectors plus hand sequences
// for re-trigger immunity, reset mid-echo and (with ECHO_JITTER_EN) the LFSR jitter sequence.
module tb_sonic_echo_responder;

    localparam int TRIG_MIN = 20;
    localparam int DLY      = 50;
    localparam int CPC      = 10;
    localparam int MAXCM    = 400;
    localparam int TO       = 5000;
    localparam int HOLD     = 100;
    // Trig fall -> echo rise, as seen from the negedge that drops trig: 2 synchroniser flops,
    // one detecting edge, then DLY cycles.
    localparam int EXP_DLY  = DLY + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [8:0] distance_cm;
    logic       echo, busy, trig_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model_lfsr;

    sonic_echo_responder #(
        .TRIG_MIN_CYC(TRIG_MIN), .ECHO_DELAY_CYC(DLY), .CYC_PER_CM(CPC),
        .MAX_CM(MAXCM), .TIMEOUT_CYC(TO), .HOLDOFF_CYC(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .distance_cm(distance_cm),
        .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int cm;
        bit exp_err;
        int exp_w;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Advances the reference LFSR once per accepted Trig; returns the extra echo cycles.
    task automatic jit_adv(input bit valid, output int extra);
        model_lfsr = lfsr_next(model_lfsr);
        extra = 0;
`ifdef ECHO_JITTER_EN
        if (valid) extra = (int'(model_lfsr[3:0]) * CPC) / 16;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_lfsr = 8'hA5;
    endtask

    task automatic pulse(input int hi);
        @(negedge clk);
        trig = 1'b1;
        repeat (hi) @(negedge clk);
        trig = 1'b0;
    endtask

    // Waits for echo to rise; flips distance_cm after the latch point to prove it is held.
    task automatic wait_echo(input int bound, output int cyc, output int errs, output int busy_lo);
        cyc = -1; errs = 0; busy_lo = 0;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if (k == 6) distance_cm = ~distance_cm;
            if (trig_err) errs++;
            if (!busy) busy_lo++;
            if (echo) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic measure_width(input int bound, output int w, output int busy_lo);
        w = 1; busy_lo = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (!busy) busy_lo++;
            if (!echo) break;
            w++;
        end
    endtask

    task automatic wait_idle(input int bound, output int cyc);
        cyc = -1;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if (!busy) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs[10];
        int d, e, b, b2, w, c, x, cnt_e, cnt_b;

        vecs[0] = '{hi: 30, cm: 25,  exp_err: 0, exp_w: 250};
        vecs[1] = '{hi: 10, cm: 25,  exp_err: 1, exp_w: 0};
        vecs[2] = '{hi: 30, cm: 25,  exp_err: 0, exp_w: 250};
        vecs[3] = '{hi: 30, cm: 0,   exp_err: 0, exp_w: TO};
        vecs[4] = '{hi: 30, cm: 401, exp_err: 0, exp_w: TO};
        vecs[5] = '{hi: 20, cm: 1,   exp_err: 0, exp_w: 10};
        vecs[6] = '{hi: 19, cm: 7,   exp_err: 1, exp_w: 0};
        vecs[7] = '{hi: 25, cm: 400, exp_err: 0, exp_w: 4000};
        vecs[8] = '{hi: 40, cm: 511, exp_err: 0, exp_w: TO};
        vecs[9] = '{hi: 30, cm: 3,   exp_err: 0, exp_w: 30};

        rst = 1'b1; trig = 1'b0; distance_cm = '0;
        model_lfsr = 8'hA5;
        repeat (4) @(negedge clk);
        check("reset_echo", int'(echo), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_trig_err", int'(trig_err), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            distance_cm = 9'(vecs[i].cm);
            pulse(vecs[i].hi);
            wait_echo(200, d, e, b);
            if (vecs[i].exp_err) begin
                check($sformatf("v%0d_trig_err_pulses", i), e, 1);
                check($sformatf("v%0d_no_echo", i), d, -1);
                check($sformatf("v%0d_busy_idle", i), int'(busy), 0);
            end else begin
                jit_adv(vecs[i].exp_w != TO, x);
                check($sformatf("v%0d_delay", i), d, EXP_DLY);
                check($sformatf("v%0d_no_trig_err", i), e, 0);
                measure_width(6000, w, b2);
                check($sformatf("v%0d_width", i), w, vecs[i].exp_w + x);
                check($sformatf("v%0d_busy_held", i), b + b2, 0);
                wait_idle(300, c);
                check($sformatf("v%0d_holdoff", i), c, HOLD);
            end
            repeat (3) @(negedge clk);
        end

        // Trig during ECHO and HOLDOFF is ignored; a level held across IDLE entry is not an edge.
        distance_cm = 9'd25;
        pulse(30);
        wait_echo(200, d, e, b);
        jit_adv(1'b1, x);
        check("retrig_delay", d, EXP_DLY);
        w = 1; cnt_e = 0;
        for (int k = 0; k < 6000 && echo; k++) begin
            if (w == 50) trig = 1'b1;
            if (w == 80) trig = 1'b0;
            @(negedge clk);
            if (trig_err) cnt_e++;
            if (echo) w++;
        end
        check("retrig_echo_width", w, 250 + x);
        repeat (10) @(negedge clk);
        pulse(30);
        repeat (19) @(negedge clk);
        trig = 1'b1;
        wait_idle(300, c);
        check("retrig_idle_reached", int'(c > 0), 1);
        cnt_b = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (trig_err) cnt_e++;
            if (echo || busy) cnt_b++;
        end
        check("retrig_no_err", cnt_e, 0);
        check("held_trig_no_measure", cnt_b, 0);
        trig = 1'b0;
        repeat (5) @(negedge clk);
        distance_cm = 9'd25;
        pulse(30);
        wait_echo(200, d, e, b);
        jit_adv(1'b1, x);
        check("after_hold_delay", d, EXP_DLY);
        measure_width(6000, w, b2);
        check("after_hold_width", w, 250 + x);
        wait_idle(300, c);

        // Reset at echo cycle 100 kills the pulse; the next Trig gives a full one.
        repeat (3) @(negedge clk);
        distance_cm = 9'd25;
        pulse(30);
        wait_echo(200, d, e, b);
        jit_adv(1'b1, x);
        repeat (99) @(negedge clk);
        check("rst_mid_echo_still_high", int'(echo), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_echo_echo", int'(echo), 0);
        check("rst_mid_echo_busy", int'(busy), 0);
        rst = 1'b0;
        model_lfsr = 8'hA5;
        repeat (3) @(negedge clk);
        distance_cm = 9'd25;
        pulse(30);
        wait_echo(200, d, e, b);
        jit_adv(1'b1, x);
        check("post_rst_delay", d, EXP_DLY);
        measure_width(6000, w, b2);
        check("post_rst_width", w, 250 + x);
        wait_idle(300, c);

`ifdef ECHO_JITTER_EN
        do_reset();
        for (int i = 0; i < 20; i++) begin
            repeat (2) @(negedge clk);
            distance_cm = 9'd25;
            pulse(30);
            wait_echo(200, d, e, b);
            jit_adv(1'b1, x);
            measure_width(6000, w, b2);
            check($sformatf("jit%0d_width", i), w, 250 + x);
            check($sformatf("jit%0d_range", i), int'(w >= 250 && w <= 259), 1);
            wait_idle(300, c);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
